// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Coefficient write master for the reconfigurable transposed FIR filter.
//   A start pulse arms the filter's coefficient-update mode. The loader then
//   walks all P_DEPTH*P_BANKS slots once. The first NT slots take host beats
//   over a valid/ready handshake; the remaining slots are written with zero.
//   After the last slot it publishes NT on oNumOfCoeff.
//
// Ports
//   iClk_12M           system clock
//   iRsn               asynchronous active-low reset
//   iLoadStart         start pulse, honoured only when idle
//   iNumTaps           requested tap count, clamped to the slot count
//   iCoeffValid        host beat valid
//   iCoeffData         host coefficient, tap 0 first
//   oCoeffReady        beat accepted this cycle (combinational)
//   oCoeffiUpdateFlag  filter coefficient-update mode
//   oCsnRam, oWrnRam   SRAM chip select / write enable, active-low
//   oAddrRam           in-bank address, 1..P_DEPTH during writes
//   oWrDtRam           SRAM write data
//   oNumOfCoeff        slot index while loading, active tap count afterwards
//   oBusy              load in progress (ARM through DONE)
//   oLoadDone          one-cycle completion pulse
module fir_coeff_loader #(
  parameter int unsigned P_DW    = 16,
  parameter int unsigned P_DEPTH = 10,
  parameter int unsigned P_BANKS = 4
) (
  input  logic            iClk_12M,
  input  logic            iRsn,
  input  logic            iLoadStart,
  input  logic [5:0]      iNumTaps,
  input  logic            iCoeffValid,
  input  logic [P_DW-1:0] iCoeffData,
  output logic            oCoeffReady,
  output logic            oCoeffiUpdateFlag,
  output logic            oCsnRam,
  output logic            oWrnRam,
  output logic [3:0]      oAddrRam,
  output logic [P_DW-1:0] oWrDtRam,
  output logic [5:0]      oNumOfCoeff,
  output logic            oBusy,
  output logic            oLoadDone
);

  localparam logic [5:0] NumSlots = 6'(P_DEPTH * P_BANKS);
  localparam logic [5:0] LastSlot = 6'(P_DEPTH * P_BANKS - 1);
  localparam logic [3:0] LastOffs = 4'(P_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StArm, StWrite, StDone} loadStateT;

  loadStateT       stateQ, stateD;
  logic [5:0]      ntQ, ntD;        // latched, clamped tap count
  logic [5:0]      slotQ, slotD;    // next slot to issue
  logic [3:0]      offsQ, offsD;    // slotQ mod P_DEPTH, kept as a counter
  logic            flagQ, flagD;
  logic            csnQ, csnD;
  logic            wrnQ, wrnD;
  logic [3:0]      addrQ, addrD;
  logic [P_DW-1:0] dataQ, dataD;
  logic [5:0]      idxQ, idxD;
  logic            busyQ, busyD;
  logic            doneQ, doneD;
  logic            handshake;
  logic            issue;

  // Ready depends only on state and slot so the host may use it to form valid.
  assign oCoeffReady = (stateQ == StWrite) && (slotQ < ntQ);
  assign handshake   = oCoeffReady & iCoeffValid;

  always_comb begin
    stateD = stateQ;
    ntD    = ntQ;
    slotD  = slotQ;
    offsD  = offsQ;
    flagD  = flagQ;
    csnD   = csnQ;
    wrnD   = wrnQ;
    addrD  = addrQ;
    dataD  = dataQ;
    idxD   = idxQ;
    busyD  = busyQ;
    doneD  = 1'b0;
    issue  = 1'b0;

    unique case (stateQ)
      StIdle: begin
        flagD = 1'b0;
        csnD  = 1'b1;
        wrnD  = 1'b1;
        addrD = '0;
        dataD = '0;
        busyD = 1'b0;
        // busyQ is still high for the cycle showing the DONE outputs.
        if (iLoadStart && !busyQ) begin
          ntD    = (iNumTaps > NumSlots) ? NumSlots : iNumTaps;
          slotD  = '0;
          offsD  = '0;
          stateD = StArm;
        end
      end
      StArm: begin
        flagD  = 1'b1;
        csnD   = 1'b1;
        wrnD   = 1'b1;
        busyD  = 1'b1;
        stateD = StWrite;
      end
      StWrite: begin
        flagD = 1'b1;
        busyD = 1'b1;
        if (slotQ < ntQ) begin
          if (handshake) begin
            csnD  = 1'b0;
            wrnD  = 1'b0;
            dataD = iCoeffData;
            issue = 1'b1;
          end else begin
            // Host stall: deselect, keep address/data/index.
            csnD = 1'b1;
            wrnD = 1'b1;
          end
        end else begin
          // Unused tap: zero-pad without waiting on the host.
          csnD  = 1'b0;
          wrnD  = 1'b0;
          dataD = '0;
          issue = 1'b1;
        end
        if (issue) begin
          addrD = offsQ + 4'd1;
          idxD  = slotQ;
          slotD = slotQ + 6'd1;
          offsD = (offsQ == LastOffs) ? 4'd0 : offsQ + 4'd1;
          if (slotQ == LastSlot) begin
            stateD = StDone;
          end
        end
      end
      StDone: begin
        flagD  = 1'b0;
        csnD   = 1'b1;
        wrnD   = 1'b1;
        idxD   = ntQ;
        busyD  = 1'b1;
        doneD  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      stateQ <= StIdle;
      ntQ    <= '0;
      slotQ  <= '0;
      offsQ  <= '0;
      flagQ  <= 1'b0;
      csnQ   <= 1'b1;
      wrnQ   <= 1'b1;
      addrQ  <= '0;
      dataQ  <= '0;
      idxQ   <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      ntQ    <= ntD;
      slotQ  <= slotD;
      offsQ  <= offsD;
      flagQ  <= flagD;
      csnQ   <= csnD;
      wrnQ   <= wrnD;
      addrQ  <= addrD;
      dataQ  <= dataD;
      idxQ   <= idxD;
      busyQ  <= busyD;
      doneQ  <= doneD;
    end
  end

  assign oCoeffiUpdateFlag = flagQ;
  assign oCsnRam           = csnQ;
  assign oWrnRam           = wrnQ;
  assign oAddrRam          = addrQ;
  assign oWrDtRam          = dataQ;
  assign oNumOfCoeff       = idxQ;
  assign oBusy             = busyQ;
  assign oLoadDone         = doneQ;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader. A host model streams coefficients
// with programmable/random stalls; the expected SRAM image, write order and
// completion time are derived from the load rules with plain arithmetic.
module tb_fir_coeff_loader;

  logic        iClk_12M = 1'b0;
  logic        iRsn;
  logic        iLoadStart;
  logic [5:0]  iNumTaps;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffiUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [3:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy;
  logic        oLoadDone;

  fir_coeff_loader #(
    .P_DW   (16),
    .P_DEPTH(10),
    .P_BANKS(4)
  ) dut (
    .iClk_12M         (iClk_12M),
    .iRsn             (iRsn),
    .iLoadStart       (iLoadStart),
    .iNumTaps         (iNumTaps),
    .iCoeffValid      (iCoeffValid),
    .iCoeffData       (iCoeffData),
    .oCoeffReady      (oCoeffReady),
    .oCoeffiUpdateFlag(oCoeffiUpdateFlag),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oAddrRam         (oAddrRam),
    .oWrDtRam         (oWrDtRam),
    .oNumOfCoeff      (oNumOfCoeff),
    .oBusy            (oBusy),
    .oLoadDone        (oLoadDone)
  );

  always #5 iClk_12M = ~iClk_12M;

  int cyc = 0;
  always @(posedge iClk_12M) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int ntIn;      // iNumTaps driven
    int stallPct;  // random stall probability per beat cycle
    int stallAt;   // beat index before which a forced stall is inserted (-1 none)
    int stallLen;  // forced stall length
    int busyOff;   // cycles after start to pulse a stray iLoadStart (0 none)
    bit sym;       // symmetric coefficient set
    int expNt;     // expected tap count published after the load
    int expLat;    // expected start-to-done latency (-1: 42 + host stalls)
  } vecT;

  logic [15:0] coef[40];
  int capIdx[$];
  int capAddr[$];
  int capData[$];

  task automatic fillCoef(input bit sym);
    for (int i = 0; i < 40; i++) coef[i] = 16'($urandom);
    if (sym) begin
      coef[0]  = 16'h0003;
      coef[1]  = 16'h0000;
      coef[2]  = 16'hFFFA;
      coef[16] = 16'h01F4;
      for (int i = 0; i < 16; i++) coef[32 - i] = coef[i];
    end
  endtask

  task automatic runLoad(input vecT v, input string tag);
    int s;
    int c;
    int jm;
    int nt;
    int stalls;
    int stallCnt;
    int doneCyc;
    int expLat;
    bit forced;
    bit finished;
    nt       = (v.ntIn > 40) ? 40 : v.ntIn;
    jm       = 0;
    stalls   = 0;
    stallCnt = 0;
    doneCyc  = -1;
    finished = 1'b0;
    fillCoef(v.sym);
    capIdx.delete();
    capAddr.delete();
    capData.delete();

    @(negedge iClk_12M);
    iLoadStart  = 1'b1;
    iNumTaps    = 6'(v.ntIn);
    iCoeffValid = 1'b0;
    s = cyc + 1;  // edge count once the start pulse has been sampled

    for (int k = 0; k < 400 && !finished; k++) begin
      @(negedge iClk_12M);
      c = cyc;
      if (doneCyc < 0 && !oLoadDone) begin
        chk({tag, " ready"}, int'(oCoeffReady), int'((c >= s + 1) && (jm < nt)));
        if (c >= s + 1) begin
          chk({tag, " flag"}, int'(oCoeffiUpdateFlag), 1);
          chk({tag, " busy"}, int'(oBusy), 1);
        end
      end
      if (!oCsnRam) begin
        chk({tag, " wrn_with_csn"}, int'(oWrnRam), 0);
        capIdx.push_back(int'(oNumOfCoeff));
        capAddr.push_back(int'(oAddrRam));
        capData.push_back(int'(oWrDtRam));
      end else if (doneCyc < 0 && !oLoadDone && capIdx.size() > 0) begin
        chk({tag, " stall_idx_hold"}, int'(oNumOfCoeff), capIdx[$]);
        chk({tag, " stall_wrn"}, int'(oWrnRam), 1);
      end
      if (oLoadDone && doneCyc < 0) begin
        doneCyc = c;
        chk({tag, " done_numcoeff"}, int'(oNumOfCoeff), v.expNt);
        chk({tag, " done_flag"}, int'(oCoeffiUpdateFlag), 0);
        chk({tag, " done_csn"}, int'(oCsnRam), 1);
        chk({tag, " done_busy"}, int'(oBusy), 1);
      end else if (doneCyc >= 0 && c == doneCyc + 1) begin
        chk({tag, " done_pulse_width"}, int'(oLoadDone), 0);
        chk({tag, " idle_busy"}, int'(oBusy), 0);
        chk({tag, " idle_flag"}, int'(oCoeffiUpdateFlag), 0);
        chk({tag, " idle_addr"}, int'(oAddrRam), 0);
        chk({tag, " idle_data"}, int'(oWrDtRam), 0);
        chk({tag, " idle_numcoeff"}, int'(oNumOfCoeff), v.expNt);
        finished = 1'b1;
      end

      // Host drive for the next edge.
      iLoadStart  = (v.busyOff > 0) && (c == s + v.busyOff);
      iCoeffValid = 1'b0;
      iCoeffData  = 16'($urandom);
      if (!finished && c >= s + 1 && jm < 40) begin
        if (jm < nt) begin
          forced = (jm == v.stallAt) && (stallCnt < v.stallLen);
          if (forced) stallCnt++;
          if (!forced && $urandom_range(99) >= v.stallPct) begin
            iCoeffValid = 1'b1;
            iCoeffData  = coef[jm];
            jm++;
          end else begin
            stalls++;
          end
        end else begin
          // Stray beats past NT must be ignored; the slot still gets zero.
          iCoeffValid = 1'($urandom_range(1));
          jm++;
        end
      end else if (!finished) begin
        iCoeffValid = 1'($urandom_range(1));
      end
    end
    iLoadStart  = 1'b0;
    iCoeffValid = 1'b0;

    if (!finished) begin
      chk({tag, " done_timeout"}, 0, 1);
    end else begin
      expLat = (v.expLat < 0) ? 42 + stalls : v.expLat;
      chk({tag, " done_latency"}, doneCyc - s, expLat);
    end
    chk({tag, " num_writes"}, capIdx.size(), 40);
    for (int i = 0; i < 40 && i < capIdx.size(); i++) begin
      chk({tag, " wr_idx"}, capIdx[i], i);
      chk({tag, " wr_addr"}, capAddr[i], (i % 10) + 1);
      chk({tag, " wr_data"}, capData[i], (i < nt) ? int'(coef[i]) : 0);
    end
  endtask

  vecT tbl[6];
  vecT rv;

  initial begin
    iRsn        = 1'b0;
    iLoadStart  = 1'b0;
    iNumTaps    = '0;
    iCoeffValid = 1'b0;
    iCoeffData  = '0;

    tbl[0] = '{ntIn: 33, stallPct: 0, stallAt: -1, stallLen: 0, busyOff: 0,  sym: 1'b1,
               expNt: 33, expLat: 42};
    tbl[1] = '{ntIn: 40, stallPct: 0, stallAt: -1, stallLen: 0, busyOff: 0,  sym: 1'b0,
               expNt: 40, expLat: 42};
    tbl[2] = '{ntIn: 5,  stallPct: 0, stallAt: 2,  stallLen: 3, busyOff: 0,  sym: 1'b0,
               expNt: 5,  expLat: 45};
    tbl[3] = '{ntIn: 0,  stallPct: 0, stallAt: -1, stallLen: 0, busyOff: 0,  sym: 1'b0,
               expNt: 0,  expLat: 42};
    tbl[4] = '{ntIn: 63, stallPct: 0, stallAt: -1, stallLen: 0, busyOff: 0,  sym: 1'b0,
               expNt: 40, expLat: 42};
    tbl[5] = '{ntIn: 12, stallPct: 0, stallAt: -1, stallLen: 0, busyOff: 10, sym: 1'b0,
               expNt: 12, expLat: 42};

    // Reset state.
    repeat (3) @(negedge iClk_12M);
    chk("rst_flag", int'(oCoeffiUpdateFlag), 0);
    chk("rst_csn", int'(oCsnRam), 1);
    chk("rst_wrn", int'(oWrnRam), 1);
    chk("rst_addr", int'(oAddrRam), 0);
    chk("rst_data", int'(oWrDtRam), 0);
    chk("rst_numcoeff", int'(oNumOfCoeff), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_done", int'(oLoadDone), 0);
    chk("rst_ready", int'(oCoeffReady), 0);
    iRsn = 1'b1;
    repeat (2) @(negedge iClk_12M);
    chk("idle_busy_after_rst", int'(oBusy), 0);

    // Reset asserted in the middle of a load.
    iLoadStart = 1'b1;
    iNumTaps   = 6'd20;
    @(negedge iClk_12M);
    iLoadStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iCoeffValid = 1'b1;
      iCoeffData  = 16'($urandom_range(1, 65535));
      @(negedge iClk_12M);
    end
    chk("midload_csn_low", int'(oCsnRam), 0);
    iRsn = 1'b0;
    #1;
    chk("midrst_csn", int'(oCsnRam), 1);
    chk("midrst_wrn", int'(oWrnRam), 1);
    chk("midrst_flag", int'(oCoeffiUpdateFlag), 0);
    chk("midrst_busy", int'(oBusy), 0);
    chk("midrst_numcoeff", int'(oNumOfCoeff), 0);
    chk("midrst_ready", int'(oCoeffReady), 0);
    iCoeffValid = 1'b0;
    @(negedge iClk_12M);
    iRsn = 1'b1;
    @(negedge iClk_12M);

    // Directed vectors; the first also shows a clean restart after reset.
    for (int i = 0; i < 6; i++) begin
      runLoad(tbl[i], $sformatf("vec%0d", i));
    end

    // Randomized loads with random host stalls.
    for (int i = 0; i < 6; i++) begin
      rv.ntIn     = $urandom_range(63);
      rv.stallPct = 30;
      rv.stallAt  = -1;
      rv.stallLen = 0;
      rv.busyOff  = 0;
      rv.sym      = 1'b0;
      rv.expNt    = (rv.ntIn > 40) ? 40 : rv.ntIn;
      rv.expLat   = -1;
      runLoad(rv, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient write master for the reconfigurable transposed FIR filter. Accepts a coefficient stream from the host over a valid/ready handshake and drives the filter's coefficient-update port (update flag, SP-SRAM chip select/write enable, bank address, write data and coefficient index). It sequences a full 40-entry load, zero-pads unused taps and then publishes the active tap count. It sits between the host/register block and `ReConf_FirFilter`, replacing hand-driven testbench sequencing.

## Interface
- P_DW, 16, coefficient width (signed)
- P_DEPTH, 10, entries per SP-SRAM bank
- P_BANKS, 4, number of banks; total slots P_DEPTH*P_BANKS = 40

- iClk_12M  in  1  12 MHz system clock
- iRsn  in  1  reset; one clock, reset is asynchronous and active-low
- iLoadStart  in  1  one-cycle start pulse; sampled only in IDLE
- iNumTaps  in  6  active tap count, latched on accepted start
- iCoeffValid  in  1  host coefficient beat valid
- iCoeffData  in  P_DW  signed coefficient, tap 0 first
- oCoeffReady  out  1  loader accepts a beat this cycle
- oCoeffiUpdateFlag  out  1  filter coefficient-update mode
- oCsnRam  out  1  SRAM chip select, active-low
- oWrnRam  out  1  SRAM write enable, active-low
- oAddrRam  out  4  bank address, 1..P_DEPTH during writes
- oWrDtRam  out  P_DW  write data
- oNumOfCoeff  out  6  write index during load; active tap count after
- oBusy  out  1  high from ARM through DONE
- oLoadDone  out  1  one-cycle pulse at load completion

## Operation
- States: IDLE, ARM, WRITE, DONE.
- IDLE: iLoadStart=1 -> latch NT = min(iNumTaps, 40), clear index j=0, go ARM.
- ARM (1 cycle): flag=1, csn=1, wrn=1; go WRITE.
- WRITE: slot j in 0..39.
  - j < NT: oCoeffReady=1 (combinational, state and j only). Handshake (valid&ready) -> next cycle csn=0, wrn=0, oWrDtRam=iCoeffData, oAddrRam=(j mod 10)+1, oNumOfCoeff=j; j++.
  - j < NT, no valid: stall; next cycle csn=1, wrn=1, addr/data/index hold; j holds.
  - j >= NT: ready=0; write zero into slot j each cycle, no stall.
  - After slot 39 issued, go DONE.
- DONE (1 cycle): oLoadDone=1, flag=0, csn=1, wrn=1, oNumOfCoeff=NT; go IDLE.
- IDLE outputs: flag=0, csn=1, wrn=1, addr=0, data=0, oNumOfCoeff holds last NT (0 after reset).
- Bank of slot j = j / 10; bank select is derived by the filter from oNumOfCoeff, not from the loader.
- Data passes through unmodified; no sign extension or saturation.

## Timing
- All outputs except oCoeffReady registered. Reset: flag=0, csn=1, wrn=1, addr=0, data=0, oNumOfCoeff=0, oBusy=0, oLoadDone=0, state IDLE.
- Start at cycle t -> ARM outputs at t+1 -> first write strobe earliest t+2.
- Write strobe appears one cycle after its handshake.
- No-stall load: 1 ARM + 40 write + 1 DONE = 42 cycles from start to oLoadDone; each host stall cycle adds one.
- iLoadStart while oBusy=1: ignored, no restart.
- iNumTaps > 40: clamped to 40. iNumTaps = 0: no beats accepted, 40 zero writes.
- iCoeffValid outside WRITE or for j >= NT: ignored, beat not consumed.
- Reset asserted mid-load: outputs take reset values asynchronously; partial SRAM contents undefined; host must reload.
- oAddrRam wraps 10 -> 1 at slots 10, 20, 30.

## Test plan
- Reset: drive iRsn=0 mid-WRITE -> immediately csn=1, wrn=1, flag=0, oBusy=0; loader restarts cleanly from next iLoadStart.
- Full symmetric load: NT=33, stream 0x0003,0x0000,-0x0006,…,0x01F4 (tap 16),…,0x0003 always valid -> 33 writes with correct data, slots 33..39 write 0x0000, oLoadDone at start+42, oNumOfCoeff=33 after.
- Address/index sweep: NT=40 -> oAddrRam sequence 1..10 four times, oNumOfCoeff 0..39 on write strobes.
- Host stalls: NT=5, deassert iCoeffValid 3 cycles before beat 2 -> 3 cycles of csn=1, index held at 1, oLoadDone at start+45.
- Boundaries: iNumTaps=0 -> 40 zero writes, oCoeffReady never high; iNumTaps=63 -> clamped, 40 beats accepted, oNumOfCoeff=40.
- Busy start: pulse iLoadStart at cycle 10 of a load -> ignored; single oLoadDone pulse only.
